// File: rtl/plab5_mcore_net_msg_to_mem_resp_if.sv
`default_nettype none
// ============================================================================
// Module   : plab5_mcore_net_msg_to_mem_resp_if
// Brief    : Network-in / memory-response-out handshake bundle for the
//            core-side memory-response receive adapter.
// Revision : 1.0 - initial release
// ============================================================================
interface plab5_mcore_net_msg_to_mem_resp_if #(
  parameter int NET_CNBITS    = 25,
  parameter int MEM_CNBITS    = 13,
  parameter int DATA_NBITS    = 32,
  parameter int SRCDEST_NBITS = 3
);
  // network side
  logic                     in_val;
  logic                     in_rdy;
  logic [NET_CNBITS-1:0]    in_msg_control;
  logic [DATA_NBITS-1:0]    in_msg_data;
  // memory-response side
  logic                     out_val;
  logic                     out_rdy;
  logic [MEM_CNBITS-1:0]    out_msg_control;
  logic [DATA_NBITS-1:0]    out_msg_data;
  logic                     out_fail;
  logic [SRCDEST_NBITS-1:0] out_src;

  // master: the environment feeding the adapter and consuming its responses
  modport master (
    output in_val, in_msg_control, in_msg_data, out_rdy,
    input  in_rdy, out_val, out_msg_control, out_msg_data, out_fail, out_src
  );

  // slave: the adapter itself
  modport slave (
    input  in_val, in_msg_control, in_msg_data, out_rdy,
    output in_rdy, out_val, out_msg_control, out_msg_data, out_fail, out_src
  );
endinterface
`default_nettype wire

// File: rtl/plab5_mcore_net_msg_to_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : plab5_mcore_net_msg_to_mem_resp
// Brief    : Core-side receive adapter. Checks destination, returned core id
//            and security domain of incoming network messages, strips the
//            network header and delivers {mem ctrl, data, fail, src} through
//            a 2-entry queue. Rejected messages are consumed and flagged.
// Options  : PLAB5_MCORE_NET_RESP_DROP_CNT_EN adds o_drop_cnt, an 8-bit
//            saturating count of dropped messages.
// Revision : 1.0 - initial release
// ============================================================================
module plab5_mcore_net_msg_to_mem_resp #(
  parameter int PORT_ID           = 0,
  parameter int NUM_PORTS         = 4,
  parameter int MEM_OPAQUE_NBITS  = 8,
  parameter int MEM_DATA_NBITS    = 32,
  parameter int NET_OPAQUE_NBITS  = 4,
  parameter int NET_SRCDEST_NBITS = 3
) (
  input  wire         clk,
  input  wire         reset,
  input  wire         i_domain,
  input  wire         i_err_clr,
  output logic        o_drop_err,
`ifdef PLAB5_MCORE_NET_RESP_DROP_CNT_EN
  output logic [7:0]  o_drop_cnt,
`endif
  plab5_mcore_net_msg_to_mem_resp_if.slave io_bus
);

  localparam int NS = NET_SRCDEST_NBITS;
  localparam int NO = NET_OPAQUE_NBITS;
  localparam int MO = MEM_OPAQUE_NBITS;
  localparam int MD = MEM_DATA_NBITS;
  localparam int c_mem_cnbits = 3 + MO + 2;
  localparam int c_net_cnbits = NS + NS + NO + c_mem_cnbits + 2;
  localparam logic [NS-1:0] c_port_id = NS'(PORT_ID);

  // A port id outside the network can never match any destination
  if (PORT_ID >= NUM_PORTS) begin : g_port_id_chk
    $error("PORT_ID must be smaller than NUM_PORTS");
  end

  // --------------------------------------------------------------------------
  // Network header decode
  // --------------------------------------------------------------------------
  logic [NS-1:0]           w_dest;
  logic [NS-1:0]           w_src;
  logic [NO-1:0]           w_net_opaque;
  logic                    w_msg_domain;
  logic                    w_fail;
  logic [c_mem_cnbits-1:0] w_mem_ctrl;
  logic [NS-1:0]           w_core_id;
  logic                    w_unused;

  assign w_dest       = io_bus.in_msg_control[c_net_cnbits-1 -: NS];
  assign w_src        = io_bus.in_msg_control[c_net_cnbits-NS-1 -: NS];
  assign w_net_opaque = io_bus.in_msg_control[c_mem_cnbits+2 +: NO];
  assign w_msg_domain = io_bus.in_msg_control[c_mem_cnbits+1];
  assign w_fail       = io_bus.in_msg_control[c_mem_cnbits];
  assign w_mem_ctrl   = io_bus.in_msg_control[c_mem_cnbits-1:0];
  // core id lives in the top bits of the memory opaque field
  assign w_core_id    = w_mem_ctrl[2+MO-1 -: NS];
  // network opaque is not needed once the message has reached its core
  assign w_unused     = ^w_net_opaque;

  // --------------------------------------------------------------------------
  // Queue state
  // --------------------------------------------------------------------------
  logic [1:0]              r_count;
  logic                    r_head;
  logic                    r_tail;
  logic [c_mem_cnbits-1:0] r_ctrl [0:1];
  logic [MD-1:0]           r_data [0:1];
  logic                    r_fail [0:1];
  logic [NS-1:0]           r_src  [0:1];

  logic       w_in_rdy;
  logic       w_out_val;
  logic       w_accept;
  logic       w_pass;
  logic       w_enq;
  logic       w_drop;
  logic       w_deq;
  logic [1:0] w_count_next;

  // in_rdy comes only from registered occupancy; a full queue never bypasses
  assign w_in_rdy  = (r_count < 2'd2);
  assign w_out_val = (r_count != 2'd0);
  assign w_accept  = io_bus.in_val && w_in_rdy;
  assign w_pass    = (w_dest == c_port_id) && (w_core_id == c_port_id) &&
                     (w_msg_domain == i_domain);
  assign w_enq     = w_accept && w_pass;
  assign w_drop    = w_accept && !w_pass;
  assign w_deq     = w_out_val && io_bus.out_rdy;

  // Occupancy update: simultaneous enqueue and dequeue leaves it unchanged
  always_comb begin
    w_count_next = r_count;
    case ({w_enq, w_deq})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Queue storage and pointers; reset discards every queued entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        r_ctrl[k] <= '0;
        r_data[k] <= '0;
        r_fail[k] <= 1'b0;
        r_src[k]  <= '0;
      end
    end else begin
      if (w_enq) begin
        r_ctrl[r_tail] <= w_mem_ctrl;
        r_data[r_tail] <= io_bus.in_msg_data;
        r_fail[r_tail] <= w_fail;
        r_src[r_tail]  <= w_src;
        r_tail         <= ~r_tail;
      end
      if (w_deq) begin
        r_head <= ~r_head;
      end
      r_count <= w_count_next;
    end
  end

  // Sticky drop flag: a drop in the same cycle as a clear wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_drop_err <= 1'b0;
    end else if (w_drop) begin
      o_drop_err <= 1'b1;
    end else if (i_err_clr) begin
      o_drop_err <= 1'b0;
    end
  end

`ifdef PLAB5_MCORE_NET_RESP_DROP_CNT_EN
  // Saturating drop counter; clear-then-count when clear and drop coincide
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_drop_cnt <= 8'd0;
    end else if (w_drop) begin
      if (i_err_clr) begin
        o_drop_cnt <= 8'd1;
      end else if (o_drop_cnt != 8'hFF) begin
        o_drop_cnt <= o_drop_cnt + 8'd1;
      end
    end else if (i_err_clr) begin
      o_drop_cnt <= 8'd0;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs present the head entry
  // --------------------------------------------------------------------------
  assign io_bus.in_rdy          = w_in_rdy;
  assign io_bus.out_val         = w_out_val;
  assign io_bus.out_msg_control = r_ctrl[r_head];
  assign io_bus.out_msg_data    = r_data[r_head];
  assign io_bus.out_fail        = r_fail[r_head];
  assign io_bus.out_src         = r_src[r_head];

endmodule
`default_nettype wire

// File: tb/tb_plab5_mcore_net_msg_to_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_plab5_mcore_net_msg_to_mem_resp
// Brief    : Directed bench for the core-side memory-response receive adapter
//            with a queue-based reference model and literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_plab5_mcore_net_msg_to_mem_resp;

  localparam int PID = 0;

  logic clk;
  logic reset;
  logic domain;
  logic err_clr;
  logic drop_err;
`ifdef PLAB5_MCORE_NET_RESP_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  plab5_mcore_net_msg_to_mem_resp_if #(
    .NET_CNBITS(25), .MEM_CNBITS(13), .DATA_NBITS(32), .SRCDEST_NBITS(3)
  ) bus ();

  plab5_mcore_net_msg_to_mem_resp #(
    .PORT_ID(PID), .NUM_PORTS(4), .MEM_OPAQUE_NBITS(8), .MEM_DATA_NBITS(32),
    .NET_OPAQUE_NBITS(4), .NET_SRCDEST_NBITS(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_domain   (domain),
    .i_err_clr  (err_clr),
    .o_drop_err (drop_err),
`ifdef PLAB5_MCORE_NET_RESP_DROP_CNT_EN
    .o_drop_cnt (drop_cnt),
`endif
    .io_bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // {dest, src, net opaque, msg_domain, fail, type, mem opaque, len}
  function automatic logic [24:0] mk(input logic [2:0] dest, input logic [2:0] src,
                                     input logic dom, input logic fail,
                                     input logic [7:0] op);
    return {dest, src, 4'h0, dom, fail, 3'd1, op, 2'd0};
  endfunction

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [12:0] ctrl;
    logic [31:0] data;
    logic        fail;
    logic [2:0]  src;
  } ent_t;

  ent_t       m_q[$];
  logic       m_err = 1'b0;
  int         m_cnt = 0;

  always @(posedge clk or posedge reset) begin
    logic        acc, deq, pass;
    logic [24:0] c;
    ent_t        e;
    if (reset) begin
      m_q.delete();
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      c    = bus.in_msg_control;
      deq  = (m_q.size() != 0) && bus.out_rdy;
      acc  = bus.in_val && (m_q.size() < 2);
      pass = (c[24:22] == 3'(PID)) && (c[9:7] == 3'(PID)) && (c[14] == domain);
      if (deq) void'(m_q.pop_front());
      if (acc && pass) begin
        e.ctrl = c[12:0];
        e.data = bus.in_msg_data;
        e.fail = c[13];
        e.src  = c[21:19];
        m_q.push_back(e);
      end
      if (err_clr) begin
        m_err = 1'b0;
        m_cnt = 0;
      end
      if (acc && !pass) begin
        m_err = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_rdy", 64'(bus.in_rdy), 64'(m_q.size() < 2));
      chk("out_val", 64'(bus.out_val), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("out_ctrl", 64'(bus.out_msg_control), 64'(m_q[0].ctrl));
        chk("out_data", 64'(bus.out_msg_data), 64'(m_q[0].data));
        chk("out_fail", 64'(bus.out_fail), 64'(m_q[0].fail));
        chk("out_src", 64'(bus.out_src), 64'(m_q[0].src));
      end
      chk("drop_err", 64'(drop_err), 64'(m_err));
`ifdef PLAB5_MCORE_NET_RESP_DROP_CNT_EN
      chk("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
`endif
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [24:0] c, input logic [31:0] d);
    bus.in_val         = 1'b1;
    bus.in_msg_control = c;
    bus.in_msg_data    = d;
  endtask

  initial begin
    reset              = 1'b1;
    domain             = 1'b0;
    err_clr            = 1'b0;
    bus.in_val         = 1'b0;
    bus.in_msg_control = '0;
    bus.in_msg_data    = '0;
    bus.out_rdy        = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_out_val", 64'(bus.out_val), 64'd0);
    chk("rst_in_rdy", 64'(bus.in_rdy), 64'd1);
    chk("rst_drop_err", 64'(drop_err), 64'd0);
    chk("rst_out_data", 64'(bus.out_msg_data), 64'd0);
    tick();

    // single valid response, one-cycle latency
    bus.out_rdy = 1'b1;
    drive(mk(3'd0, 3'd1, 1'b0, 1'b0, 8'h05), 32'hDEADBEEF);
    tick();
    bus.in_val = 1'b0;
    chk("t1_out_val", 64'(bus.out_val), 64'd1);
    chk("t1_data", 64'(bus.out_msg_data), 64'hDEADBEEF);
    chk("t1_opaque", 64'(bus.out_msg_control[9:2]), 64'h05);
    chk("t1_fail", 64'(bus.out_fail), 64'd0);
    chk("t1_drop_err", 64'(drop_err), 64'd0);
    tick();

    // three back-to-back with consumer stalled
    bus.out_rdy = 1'b0;
    drive(mk(3'd0, 3'd1, 1'b0, 1'b0, 8'h11), 32'h1111);
    tick();
    drive(mk(3'd0, 3'd2, 1'b0, 1'b0, 8'h12), 32'h2222);
    tick();
    drive(mk(3'd0, 3'd3, 1'b0, 1'b0, 8'h13), 32'h3333);
    tick();
    chk("t2_full_in_rdy", 64'(bus.in_rdy), 64'd0);
    chk("t2_head_stable", 64'(bus.out_msg_data), 64'h1111);
    tick();
    bus.out_rdy = 1'b1;
    tick();
    chk("t2_in_rdy_after_deq", 64'(bus.in_rdy), 64'd1);
    chk("t2_second_head", 64'(bus.out_msg_data), 64'h2222);
    tick();
    bus.in_val = 1'b0;
    chk("t2_third_queued", 64'(bus.out_msg_data), 64'h3333);
    tick();
    tick();

    // domain mismatch drop and clear
    drive(mk(3'd0, 3'd1, 1'b1, 1'b0, 8'h05), 32'hBAD0);
    tick();
    bus.in_val = 1'b0;
    chk("t3_drop_err", 64'(drop_err), 64'd1);
    chk("t3_out_val", 64'(bus.out_val), 64'd0);
`ifdef PLAB5_MCORE_NET_RESP_DROP_CNT_EN
    chk("t3_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3_cleared", 64'(drop_err), 64'd0);

    // wrong dest, then wrong core id in opaque
    drive(mk(3'd2, 3'd1, 1'b0, 1'b0, 8'h05), 32'hBAD1);
    tick();
    drive(mk(3'd0, 3'd1, 1'b0, 1'b0, 8'h25), 32'hBAD2);
    tick();
    bus.in_val = 1'b0;
    chk("t4_out_val", 64'(bus.out_val), 64'd0);
`ifdef PLAB5_MCORE_NET_RESP_DROP_CNT_EN
    chk("t4_drop_cnt", 64'(drop_cnt), 64'd2);
`endif
    // clear coinciding with a drop: clear then set
    err_clr = 1'b1;
    drive(mk(3'd2, 3'd1, 1'b0, 1'b0, 8'h05), 32'hBAD3);
    tick();
    bus.in_val = 1'b0;
    err_clr    = 1'b0;
    chk("t4_clr_and_drop", 64'(drop_err), 64'd1);
`ifdef PLAB5_MCORE_NET_RESP_DROP_CNT_EN
    chk("t4_clr_and_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // fail bit and source forwarded
    drive(mk(3'd0, 3'd3, 1'b0, 1'b1, 8'h07), 32'hCAFE0001);
    tick();
    bus.in_val = 1'b0;
    chk("t5_fail", 64'(bus.out_fail), 64'd1);
    chk("t5_src", 64'(bus.out_src), 64'd3);
    tick();

    // domain change with an entry queued
    bus.out_rdy = 1'b0;
    drive(mk(3'd0, 3'd1, 1'b0, 1'b0, 8'h0A), 32'hA0A0);
    tick();
    bus.in_val = 1'b0;
    domain     = 1'b1;
    tick();
    chk("t6_old_entry_kept", 64'(bus.out_msg_data), 64'hA0A0);
    drive(mk(3'd0, 3'd1, 1'b1, 1'b0, 8'h0B), 32'hB0B0);
    tick();
    bus.in_val  = 1'b0;
    bus.out_rdy = 1'b1;
    tick();
    tick();
    tick();
    domain = 1'b0;

    // reset with two entries queued
    bus.out_rdy = 1'b0;
    drive(mk(3'd0, 3'd1, 1'b0, 1'b0, 8'h01), 32'h0101);
    tick();
    drive(mk(3'd0, 3'd2, 1'b0, 1'b0, 8'h02), 32'h0202);
    tick();
    bus.in_val = 1'b0;
    chk("t7_full", 64'(bus.in_rdy), 64'd0);
    reset = 1'b1;
    #1;
    chk("t7_async_out_val", 64'(bus.out_val), 64'd0);
    chk("t7_async_in_rdy", 64'(bus.in_rdy), 64'd1);
    tick();
    reset = 1'b0;
    tick();
    tick();

`ifdef PLAB5_MCORE_NET_RESP_DROP_CNT_EN
    // saturation of the drop counter
    bus.out_rdy = 1'b1;
    drive(mk(3'd2, 3'd1, 1'b0, 1'b0, 8'h05), 32'h0);
    for (int i = 0; i < 260; i++) tick();
    bus.in_val = 1'b0;
    chk("t8_saturate", 64'(drop_cnt), 64'd255);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
